// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - signed ALU: single-cycle add/sub/mul, sequential restoring divide/modulo
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [3:0]           op,
  input  logic [WIDTH-1:0]     in1,
  input  logic [WIDTH-1:0]     in2,
  input  logic                 nvalid_data,
  output logic [2*WIDTH-1:0]   out,
  output logic                 zero,
  output logic                 error,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd4;
  localparam logic [3:0] OP_DIV = 4'd8;
  localparam logic [3:0] OP_MOD = 4'd9;

  typedef enum logic {IDLE, DIVIDE} state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      dvd_q, dvd_d;
  logic [WIDTH-1:0]      dvs_q, dvs_d;
  logic [WIDTH-1:0]      rem_q, rem_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  is_mod_q, is_mod_d;
  logic                  neg_quo_q, neg_quo_d;
  logic                  neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0]    out_q, out_d;
  logic                  zero_q, zero_d;
  logic                  error_q, error_d;
  logic                  done_q, done_d;

  logic signed [2*WIDTH-1:0] a_ext, b_ext;
  logic [WIDTH-1:0]      mag1, mag2;
  logic [WIDTH:0]        rem_sh;
  logic                  fits;
  logic [WIDTH-1:0]      rem_nx, quo_nx;
  logic [2*WIDTH-1:0]    quo_ext, rem_ext;
  logic [2*WIDTH-1:0]    res;
  logic                  res_err, load;

  assign a_ext = {{WIDTH{in1[WIDTH-1]}}, in1};
  assign b_ext = {{WIDTH{in2[WIDTH-1]}}, in2};
  assign mag1  = in1[WIDTH-1] ? ({WIDTH{1'b0}} - in1) : in1;
  assign mag2  = in2[WIDTH-1] ? ({WIDTH{1'b0}} - in2) : in2;

  // One restoring step: the dividend register shifts left and collects quotient bits.
  assign rem_sh  = {rem_q, dvd_q[WIDTH-1]};
  assign fits    = rem_sh >= {1'b0, dvs_q};
  assign rem_nx  = fits ? (rem_sh[WIDTH-1:0] - dvs_q) : rem_sh[WIDTH-1:0];
  assign quo_nx  = {dvd_q[WIDTH-2:0], fits};
  assign quo_ext = {{WIDTH{1'b0}}, quo_nx};
  assign rem_ext = {{WIDTH{1'b0}}, rem_nx};

  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    is_mod_d  = is_mod_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    res       = '0;
    res_err   = 1'b0;
    load      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          load = 1'b1;
          if (nvalid_data) begin
            res     = '1;
            res_err = 1'b1;
          end else begin
            case (op)
              OP_ADD: res = a_ext + b_ext;
              OP_SUB: res = a_ext - b_ext;
              OP_MUL: res = a_ext * b_ext;
              OP_DIV, OP_MOD: begin
                if (in2 == '0) begin
                  res     = '1;
                  res_err = 1'b1;
                end else begin
                  load      = 1'b0;
                  state_d   = DIVIDE;
                  dvd_d     = mag1;
                  dvs_d     = mag2;
                  rem_d     = '0;
                  cnt_d     = '0;
                  is_mod_d  = (op == OP_MOD);
                  neg_quo_d = in1[WIDTH-1] ^ in2[WIDTH-1];
                  neg_rem_d = in1[WIDTH-1];
                end
              end
              default: res = '0;
            endcase
          end
        end
      end
      DIVIDE: begin
        dvd_d = quo_nx;
        rem_d = rem_nx;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = IDLE;
          load    = 1'b1;
          // Magnitudes are widened before negation so -2^(W-1)/-1 stays exact.
          if (is_mod_q) res = neg_rem_q ? ({2*WIDTH{1'b0}} - rem_ext) : rem_ext;
          else          res = neg_quo_q ? ({2*WIDTH{1'b0}} - quo_ext) : quo_ext;
        end
      end
      default: state_d = IDLE;
    endcase

    out_d   = load ? res : out_q;
    zero_d  = load ? (res == '0) : zero_q;
    error_d = load ? res_err : error_q;
    done_d  = load;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      is_mod_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      out_q     <= '0;
      zero_q    <= 1'b1;
      error_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      is_mod_q  <= is_mod_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      out_q     <= out_d;
      zero_q    <= zero_d;
      error_q   <= error_d;
      done_q    <= done_d;
    end
  end

  assign out   = out_q;
  assign zero  = zero_q;
  assign error = error_q;
  assign done  = done_q;
  assign busy  = (state_q == DIVIDE);

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq (WIDTH=8)
module tb_alu_seq;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [3:0]     op = 4'd0;
  logic [W-1:0]   in1 = '0;
  logic [W-1:0]   in2 = '0;
  logic           nvalid_data = 1'b0;
  logic [2*W-1:0] out;
  logic           zero, error, busy, done;

  int n_pass = 0;
  int n_total = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .in1(in1), .in2(in2),
    .nvalid_data(nvalid_data), .out(out), .zero(zero), .error(error),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        nv;
    logic [15:0] o;
    logic        e;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input longint got, input longint exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic void model(input logic [3:0] mop, input logic [7:0] a, input logic [7:0] b,
                                input logic nv, output logic [15:0] o, output logic e,
                                output int lat);
    longint sa, sb;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lat = 1;
    e   = 1'b0;
    o   = 16'h0;
    if (nv) begin
      o = 16'hFFFF; e = 1'b1;
    end else begin
      case (mop)
        4'd0: o = 16'(sa + sb);
        4'd2: o = 16'(sa - sb);
        4'd4: o = 16'(sa * sb);
        4'd8, 4'd9: begin
          if (sb == 0) begin
            o = 16'hFFFF; e = 1'b1;
          end else begin
            lat = W + 1;
            o = (mop == 4'd8) ? 16'(sa / sb) : 16'(sa % sb);
          end
        end
        default: o = 16'h0;
      endcase
    end
  endfunction

  // Must be entered right after a falling edge; returns on the falling edge where done is seen.
  task automatic run(input logic [3:0] o_op, input logic [7:0] a, input logic [7:0] b,
                     input logic nv, output logic [15:0] o, output logic e, output logic z,
                     output int lat, output int busy_cnt, output logic busy_at_done);
    op = o_op; in1 = a; in2 = b; nvalid_data = nv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy_cnt = 0;
    while (!done && lat < 30) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    o = out; e = error; z = zero; busy_at_done = busy;
  endtask

  logic [15:0] r_o, m_o;
  logic        r_e, r_z, r_b, m_e;
  int          r_lat, r_bc, m_lat, cyc;

  initial begin
    vecs[0]  = '{4'd0, 8'd100, 8'd100, 1'b0, 16'd200,  1'b0, 1};
    vecs[1]  = '{4'd4, 8'h80,  8'h80,  1'b0, 16'h4000, 1'b0, 1};
    vecs[2]  = '{4'd2, 8'd5,   8'd5,   1'b0, 16'h0000, 1'b0, 1};
    vecs[3]  = '{4'd8, 8'hF9,  8'd2,   1'b0, 16'hFFFD, 1'b0, 9};
    vecs[4]  = '{4'd9, 8'hF9,  8'd2,   1'b0, 16'hFFFF, 1'b0, 9};
    vecs[5]  = '{4'd8, 8'd9,   8'd0,   1'b0, 16'hFFFF, 1'b1, 1};
    vecs[6]  = '{4'd0, 8'd3,   8'd4,   1'b1, 16'hFFFF, 1'b1, 1};
    vecs[7]  = '{4'd8, 8'h80,  8'hFF,  1'b0, 16'd128,  1'b0, 9};
    vecs[8]  = '{4'd9, 8'd7,   8'hFE,  1'b0, 16'h0001, 1'b0, 9};
    vecs[9]  = '{4'd3, 8'd7,   8'd7,   1'b0, 16'h0000, 1'b0, 1};
    vecs[10] = '{4'd8, 8'd127, 8'h80,  1'b0, 16'h0000, 1'b0, 9};
    vecs[11] = '{4'd9, 8'h80,  8'd7,   1'b0, 16'hFFFE, 1'b0, 9};
    vecs[12] = '{4'd0, 8'h80,  8'h80,  1'b0, 16'hFF00, 1'b0, 1};
    vecs[13] = '{4'd9, 8'd9,   8'd0,   1'b1, 16'hFFFF, 1'b1, 1};

    repeat (2) @(negedge clk);
    chk("reset_out", out, 0);
    chk("reset_zero", zero, 1);
    chk("reset_error", error, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table; back-to-back ops also start in the cycle done pulses.
    for (int i = 0; i < 14; i++) begin
      run(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].nv, r_o, r_e, r_z, r_lat, r_bc, r_b);
      chk($sformatf("vec%0d_out", i), r_o, vecs[i].o);
      chk($sformatf("vec%0d_err", i), r_e, vecs[i].e);
      chk($sformatf("vec%0d_zero", i), r_z, (vecs[i].o == 16'h0));
      chk($sformatf("vec%0d_lat", i), r_lat, vecs[i].lat);
      chk($sformatf("vec%0d_busycnt", i), r_bc, vecs[i].lat - 1);
      chk($sformatf("vec%0d_busy_at_done", i), r_b, 0);
    end

    // Randomized ops against the arithmetic model.
    for (int i = 0; i < 150; i++) begin
      logic [3:0] rop;
      logic [7:0] ra, rb;
      logic       rnv;
      case ($urandom_range(0, 6))
        0: rop = 4'd0;
        1: rop = 4'd2;
        2: rop = 4'd4;
        3, 4: rop = 4'd8;
        5: rop = 4'd9;
        default: rop = 4'($urandom_range(0, 15));
      endcase
      ra  = 8'($urandom);
      rb  = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
      rnv = ($urandom_range(0, 15) == 0);
      model(rop, ra, rb, rnv, m_o, m_e, m_lat);
      run(rop, ra, rb, rnv, r_o, r_e, r_z, r_lat, r_bc, r_b);
      chk($sformatf("rnd%0d_out op%0d %0h %0h", i, rop, ra, rb), r_o, m_o);
      chk($sformatf("rnd%0d_err", i), r_e, m_e);
      chk($sformatf("rnd%0d_zero", i), r_z, (m_o == 16'h0));
      chk($sformatf("rnd%0d_lat", i), r_lat, m_lat);
    end

    // start pulses while busy must be ignored.
    op = 4'd8; in1 = 8'd100; in2 = 8'd7; nvalid_data = 1'b0; start = 1'b1;
    @(negedge clk);
    cyc = 1;
    while (!done && cyc < 30) begin
      start = (cyc == 2 || cyc == 5);
      if (start) begin op = 4'd0; in1 = 8'd1; in2 = 8'd1; end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("ignore_lat", cyc, 9);
    chk("ignore_out", out, 14);
    @(negedge clk);
    chk("done_single_pulse", done, 0);
    @(negedge clk);
    chk("hold_out", out, 14);
    chk("hold_busy", busy, 0);

    // Reset aborts an in-flight division.
    run(4'd0, 8'd3, 8'd4, 1'b0, r_o, r_e, r_z, r_lat, r_bc, r_b);
    chk("pre_reset_out", r_o, 7);
    op = 4'd8; in1 = 8'd100; in2 = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_out", out, 0);
    chk("rst_zero", zero, 1);
    chk("rst_done", done, 0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_done", done, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle_done", done, 0);
    run(4'd0, 8'd1, 8'd1, 1'b0, r_o, r_e, r_z, r_lat, r_bc, r_b);
    chk("post_rst_add_out", r_o, 2);
    chk("post_rst_add_lat", r_lat, 1);
    chk("post_rst_add_err", r_e, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand width in bits (minimum 2).
REQ-002 SHALL have port clk, input, 1, sole clock; all state on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request a new operation; sampled only while busy=0.
REQ-005 SHALL have port op, input, 4, opcode: ADD=0, SUB=2, MUL=4, DIV=8, MOD=9.
REQ-006 SHALL have ports in1 and in2, input, WIDTH each, signed two's-complement operands.
REQ-007 SHALL have port nvalid_data, input, 1, marks the operands invalid; sampled with start.
REQ-008 SHALL have port out, output, 2*WIDTH, signed registered result.
REQ-009 SHALL have port zero, output, 1, registered; high when out==0.
REQ-010 SHALL have port error, output, 1, registered error flag for the last operation.
REQ-011 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-012 SHALL have port done, output, 1, single-cycle pulse when out/zero/error are updated.

Function
REQ-013 SHALL implement states IDLE and DIVIDE; busy=1 exactly in DIVIDE.
REQ-014 SHALL capture op, in1, in2 and nvalid_data internally on the edge where start=1 in IDLE.
REQ-015 SHALL ignore start (no capture, no effect) while busy=1.
REQ-016 SHALL, for ADD/SUB/MUL, load sign-extended in1+in2, in1-in2 or full-precision in1*in2 into out, assert done on the edge after start (latency 1), and remain in IDLE.
REQ-017 SHALL, when nvalid_data=1 at start, ignore op, set out=-1 (all ones) and error=1 with latency 1, taking precedence over every other case.
REQ-018 SHALL, for DIV/MOD with in2==0, set out=-1 and error=1 with latency 1 and not enter DIVIDE.
REQ-019 SHALL, for DIV/MOD with in2!=0, enter DIVIDE and run a sequential restoring divider on the operand magnitudes, one quotient bit per cycle, for exactly WIDTH cycles.
REQ-020 SHALL, on leaving DIVIDE, load out, pulse done and return to IDLE, giving latency WIDTH+1 cycles from the start edge.
REQ-021 SHALL, for DIV, produce the quotient truncated toward zero, negated when the operand signs differ, and sign-extended to 2*WIDTH.
REQ-022 SHALL, for MOD, produce the remainder carrying the sign of in1, sign-extended to 2*WIDTH.
REQ-023 SHALL, for DIV with in1=-2^(WIDTH-1) and in2=-1, output +2^(WIDTH-1) correctly in 2*WIDTH bits with error=0.
REQ-024 SHALL, for undefined opcodes, set out=0 and error=0 with latency 1.
REQ-025 SHALL update zero together with out in every case, so zero=(new out==0).
REQ-026 SHALL hold out, zero and error stable between done pulses.
REQ-027 SHALL accept a new start in the same cycle in which done pulses, provided busy=0.
REQ-028 SHALL compute ADD and SUB with 2*WIDTH-bit sign-extended operands so that no overflow occurs.

Reset
REQ-029 SHALL, while rst_n=0, force state=IDLE, out=0, zero=1, error=0, busy=0 and done=0, independent of clk.
REQ-030 SHALL, when reset is asserted mid-DIVIDE, abort the division with no done pulse; after release the block SHALL accept start normally.

Verification
REQ-031 SHALL cover: WIDTH=8, ADD 100+100 -> next cycle out=16'd200, done=1, zero=0, busy stays 0.
REQ-032 SHALL cover: MUL -128*-128 -> out=16'h4000 with latency 1; SUB 5-5 -> out=0, zero=1.
REQ-033 SHALL cover: DIV -7/2 -> busy=1 for 8 cycles, done on cycle 9, out=16'hFFFD; MOD -7/2 -> out=16'hFFFF, error=0.
REQ-034 SHALL cover: DIV 9/0 -> latency 1, out=16'hFFFF, error=1; and nvalid_data=1 with ADD -> out=16'hFFFF, error=1.
REQ-035 SHALL cover: start pulsed again during DIV 100/7 -> ignored, result out=14; DIV -128/-1 -> out=16'd128.
REQ-036 SHALL cover: rst_n low during cycle 4 of a DIV -> busy=0, out=0, zero=1 immediately, no done; a following ADD 1+1 -> out=2.
